// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop walk the
// operands LSB-first over WIDTH cycles, with a start/ready/busy/done handshake.
module serial_addsub #(
  parameter int WIDTH  = 8,
  parameter bit SUB_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic sub_eff;
  logic accept;
  logic last_bit;
  logic bit_sum;
  logic cy_next;

  // Subtraction is a + ~b + 1: invert B on capture and force the carry-in.
  assign sub_eff  = sub & SUB_EN;
  assign accept   = start & (state_q == ST_IDLE);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign bit_sum  = opa_q[0] ^ opb_q[0] ^ cy_q;
  assign cy_next  = (opa_q[0] & opb_q[0]) | (cy_q & (opa_q[0] ^ opb_q[0]));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaulting every combinational output first keeps any unlisted
    // path from inferring a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)    state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = (state_q == ST_IDLE);
    busy  = (state_q == ST_RUN);
    done  = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    s_d     = s_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    if (accept) begin
      opa_d = a;
      opb_d = sub_eff ? ~b : b;
      cy_d  = sub_eff ? 1'b1 : cin;
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      opa_d          = opa_q >> 1;
      opb_d          = opb_q >> 1;
      cy_d           = cy_next;
      res_d[cnt_q]   = bit_sum;
      cnt_d          = cnt_q + CW'(1);
      // Visible results change only on entry to DONE; cy_q here is the carry
      // into the MSB, cy_next the carry out of it.
      if (last_bit) begin
        s_d     = res_d;
        carry_d = cy_next;
        ovf_d   = cy_q ^ cy_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand, carry and partial-result registers are reset as well,
    // so an op aborted by reset leaves no carry or bits behind for the next one.
    if (!rst_n) begin
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      s_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s     = s_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (8-bit, 8-bit add-only, 4-bit)
// checked every cycle against an arithmetic model, plus literal vectors.
module tb_serial_addsub;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cin   = 1'b0;
  logic       sub   = 1'b0;
  logic [7:0] a     = 8'h00;
  logic [7:0] b     = 8'h00;

  logic       rdy0, bsy0, dn0, cy0, ov0;
  logic       rdy1, bsy1, dn1, cy1, ov1;
  logic       rdy2, bsy2, dn2, cy2, ov2;
  logic [7:0] s8, s8n;
  logic [3:0] s4;

  int n_cmp = 0;
  int n_err = 0;

  initial forever #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .SUB_EN(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .ready(rdy0), .busy(bsy0), .done(dn0), .s(s8), .carry(cy0), .ovf(ov0));

  serial_addsub #(.WIDTH(8), .SUB_EN(1'b0)) u8n (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .ready(rdy1), .busy(bsy1), .done(dn1), .s(s8n), .carry(cy1), .ovf(ov1));

  serial_addsub #(.WIDTH(4), .SUB_EN(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub),
    .ready(rdy2), .busy(bsy2), .done(dn2), .s(s4), .carry(cy2), .ovf(ov2));

  // Packed view per instance: {ready, busy, done, carry, ovf, s[7:0]}
  logic [12:0] out_pk [3];
  assign out_pk[0] = {rdy0, bsy0, dn0, cy0, ov0, s8};
  assign out_pk[1] = {rdy1, bsy1, dn1, cy1, ov1, s8n};
  assign out_pk[2] = {rdy2, bsy2, dn2, cy2, ov2, 4'h0, s4};

  string nm   [3] = '{"u8", "u8n", "u4"};
  int    wd   [3] = '{8, 8, 4};
  bit    se_p [3] = '{1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Result from plain integer arithmetic: {carry, ovf, s[7:0]}
  function automatic logic [9:0] model_res(input int w, input bit se, input logic [7:0] ai,
                                           input logic [7:0] bi, input logic ci, input logic si);
    int unsigned mask, av, bv, sum;
    int          sa, sbv, r, half;
    logic        c, o;
    mask = (32'd1 << w) - 32'd1;
    av   = {24'd0, ai} & mask;
    bv   = {24'd0, bi} & mask;
    half = 1 << (w - 1);
    sa   = int'(av);
    sbv  = int'(bv);
    if (sa >= half) sa = sa - 2 * half;
    if (sbv >= half) sbv = sbv - 2 * half;
    if (si && se) begin
      r   = sa - sbv;
      c   = (av >= bv);
      sum = (av - bv) & mask;
    end else begin
      r   = sa + sbv + int'(ci);
      sum = av + bv + {31'd0, ci};
      c   = ((sum >> w) & 32'd1) != 0;
      sum = sum & mask;
    end
    o = (r < -half) || (r >= half);
    return {c, o, sum[7:0]};
  endfunction

  // Model: an op is accepted when start is seen and the instance has been free
  // for WIDTH+2 edges since its previous accept.
  int          edge_n = 0;
  bit          has_op [3] = '{default: 1'b0};
  int          acc    [3] = '{default: 0};
  logic [9:0]  held   [3] = '{default: '0};
  logic [9:0]  pend   [3] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n <= 0;
      for (int k = 0; k < 3; k++) begin
        has_op[k] <= 1'b0;
        acc[k]    <= 0;
        held[k]   <= '0;
        pend[k]   <= '0;
      end
    end else begin
      edge_n <= edge_n + 1;
      for (int k = 0; k < 3; k++) begin
        if (start && (!has_op[k] || edge_n >= acc[k] + wd[k] + 2)) begin
          held[k]   <= has_op[k] ? pend[k] : held[k];
          pend[k]   <= model_res(wd[k], se_p[k], a, b, cin, sub);
          acc[k]    <= edge_n;
          has_op[k] <= 1'b1;
        end
      end
    end
  end

  function automatic logic [12:0] expect_out(input int k);
    logic       r_v, b_v, d_v;
    logic [9:0] res;
    int         d;
    r_v = 1'b1;
    b_v = 1'b0;
    d_v = 1'b0;
    res = rst_n ? held[k] : 10'd0;
    if (rst_n && has_op[k]) begin
      d   = edge_n - 1 - acc[k];
      b_v = (d < wd[k]);
      d_v = (d == wd[k]);
      r_v = (d > wd[k]);
      if (d >= wd[k]) res = pend[k];
    end
    return {r_v, b_v, d_v, res};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check({nm[k], " outputs"}, {19'd0, out_pk[k]}, {19'd0, expect_out(k)});
    end
  end

  // Must be called at a negedge with every instance idle.
  task automatic run_op(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                        input logic ci, input logic si, input logic [9:0] exp_res);
    a = ai; b = bi; cin = ci; sub = si; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check({tag, " busy before done"}, {29'd0, rdy0, bsy0, dn0}, 32'h2);
    @(negedge clk);
    check({tag, " result at done"}, {21'd0, dn0, cy0, ov0, s8}, {21'd0, 1'b1, exp_res});
    @(negedge clk);
    check({tag, " ready after done"}, {30'd0, rdy0, dn0}, 32'h2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pattern;
    logic [3:0]  a4, b4;

    // Reset with random inputs
    repeat (3) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      sub = 1'($urandom); start = 1'($urandom);
      @(negedge clk);
      check("reset u8",  {19'd0, out_pk[0]}, 32'h1000);
      check("reset u8n", {19'd0, out_pk[1]}, 32'h1000);
      check("reset u4",  {19'd0, out_pk[2]}, 32'h1000);
    end
    start = 1'b0;
    rst_n = 1'b1;

    check("model 3-5 w4", {22'd0, model_res(4, 1'b1, 8'h03, 8'h05, 1'b0, 1'b1)}, {22'd0, 2'b00, 8'h0E});
    check("model 3+5 w4", {22'd0, model_res(4, 1'b1, 8'h03, 8'h05, 1'b0, 1'b0)}, {22'd0, 2'b01, 8'h08});

    run_op("FF+01",      8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h00});
    run_op("7F+01",      8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h80});
    run_op("05-07",      8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE});
    check("u8n sub ignored", {22'd0, cy1, ov1, s8n}, {22'd0, 2'b00, 8'h0C});
    run_op("80-01",      8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
    run_op("05-07 cin1", 8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFE});
    check("u8n add cin1", {22'd0, cy1, ov1, s8n}, {22'd0, 2'b00, 8'h0D});
    run_op("10+20+1",    8'h10, 8'h20, 1'b1, 1'b0, {1'b0, 1'b0, 8'h31});

    // start held high: u4 must complete ops 6 clocks apart
    a = 8'h03; b = 8'h05; cin = 1'b0; sub = 1'b0; start = 1'b1;
    pattern = '0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      pattern[j] = dn2;
    end
    start = 1'b0;
    check("u4 held-start done pattern", {20'd0, pattern}, {20'd0, 12'b0100_0001_0000});
    check("u4 3+5 result", {26'd0, cy2, ov2, s4}, {26'd0, 2'b01, 4'h8});
    repeat (9) @(negedge clk);

    // Operands changing and a stray start during RUN
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'hFF; sub = 1'b1; cin = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("protocol result", {21'd0, dn0, cy0, ov0, s8}, {21'd0, 1'b1, 2'b00, 8'h46});
    @(negedge clk);
    check("protocol ready", {30'd0, rdy0, dn0}, 32'h2);
    repeat (3) @(negedge clk);
    check("protocol no second done", {23'd0, dn0, s8}, {23'd0, 1'b0, 8'h46});

    // Reset in the middle of an op that generates carries
    a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-op reset u8", {19'd0, out_pk[0]}, 32'h1000);
    check("mid-op reset u4", {19'd0, out_pk[2]}, 32'h1000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post-reset 01+01", 8'h01, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h02});

    // Exhaustive 4-bit sweep; the 8-bit instances see mixed operands
    for (int i = 0; i < 1024; i++) begin
      a4 = i[3:0];
      b4 = i[7:4];
      a = {b4, a4}; b = {a4, b4}; cin = i[8]; sub = i[9]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
